// File: rtl/seg_display_sched.sv
// seg_display_sched
// Time-shares the 4-digit hex display between N_REQ requesters. One requester
// is granted at a time in round-robin order for HOLD_CYCLES cycles. A GAP of
// GAP_CYCLES cycles showing IDLE_VALUE separates consecutive grants.
//
// Ports
//   sys_clk     in   1          system clock
//   reset       in   1          asynchronous, active-high reset
//   req         in   N_REQ      level request per requester, held until done/abort
//   req_data    in   16*N_REQ   value of requester i on bits [16*i+15:16*i]
//   grant       out  N_REQ      one-hot (or zero) grant, registered
//   done        out  N_REQ      1-cycle pulse when requester's hold time expires
//   owner       out  3          index of granted requester, 0 when none
//   busy        out  1          high while a grant is active
//   disp_value  out  16         value for the segment driver, registered
module seg_display_sched #(
    parameter int unsigned N_REQ       = 3,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES  = 5_000_000,
    parameter logic [15:0] IDLE_VALUE  = 16'h0000
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [16*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      grant,
    output logic [N_REQ-1:0]      done,
    output logic [2:0]            owner,
    output logic                  busy,
    output logic [15:0]           disp_value
);

    localparam int unsigned HW      = $clog2(HOLD_CYCLES) + 1;
    localparam int unsigned GW      = $clog2(GAP_CYCLES) + 1;
    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned DW      = 16 * MAX_REQ;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SHOW = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t          state;
    logic [HW-1:0]   hold_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [2:0]      last;

    // Inputs widened to the 8-requester maximum so 3-bit indices always fit.
    logic [MAX_REQ-1:0] req_ext;
    logic [DW-1:0]      data_ext;

    assign req_ext  = MAX_REQ'(req);
    assign data_ext = DW'(req_data);

    logic               owner_req;
    logic [15:0]        owner_data;
    logic [2:0]         cand;
    logic               win_found;
    logic [2:0]         win_idx;
    logic [N_REQ-1:0]   win_onehot;

    // Request level and live data of the current owner.
    always_comb begin
        owner_req  = req_ext[owner];
        owner_data = 16'h0000;
        for (int i = 0; i < int'(MAX_REQ); i++) begin
            if (owner == 3'(i)) begin
                owner_data = data_ext[16*i +: 16];
            end
        end
    end

    // Round-robin search starting just after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 3'd0;
        for (int i = 1; i <= int'(N_REQ); i++) begin
            cand = 3'((int'(last) + i) % int'(N_REQ));
            if (!win_found && req_ext[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_onehot = N_REQ'(8'b0000_0001 << win_idx);
    end

    // Scheduler state machine with registered outputs.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            grant      <= '0;
            done       <= '0;
            owner      <= 3'd0;
            busy       <= 1'b0;
            disp_value <= IDLE_VALUE;
            last       <= 3'(N_REQ - 1);
            hold_cnt   <= '0;
            gap_cnt    <= '0;
        end else begin
            done <= '0;
            case (state)
                S_IDLE: begin
                    disp_value <= IDLE_VALUE;
                    if (win_found) begin
                        state    <= S_SHOW;
                        grant    <= win_onehot;
                        owner    <= win_idx;
                        busy     <= 1'b1;
                        last     <= win_idx;
                        hold_cnt <= '0;
                    end
                end
                S_SHOW: begin
                    // Abort wins over expiry; the display blanks as the grant ends.
                    if (!owner_req || hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                        if (owner_req) begin
                            done <= grant;
                        end
                        state      <= S_GAP;
                        grant      <= '0;
                        owner      <= 3'd0;
                        busy       <= 1'b0;
                        hold_cnt   <= '0;
                        gap_cnt    <= '0;
                        disp_value <= IDLE_VALUE;
                    end else begin
                        hold_cnt   <= hold_cnt + HW'(1);
                        disp_value <= owner_data;
                    end
                end
                S_GAP: begin
                    disp_value <= IDLE_VALUE;
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        state   <= S_IDLE;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    grant      <= '0;
                    owner      <= 3'd0;
                    busy       <= 1'b0;
                    disp_value <= IDLE_VALUE;
                    hold_cnt   <= '0;
                    gap_cnt    <= '0;
                end
            endcase
        end
    end

endmodule
